// File: rtl/uart_bridge_pkg.sv
// rtl/uart_bridge_pkg.sv - state encodings and baud prescale table for the USB-UART flow scheduler
package uart_bridge_pkg;

   typedef enum logic {
      RX_HOLD    = 1'b0,
      RX_RELEASE = 1'b1
   } rx_state_e;

   typedef enum logic [1:0] {
      CFG_IDLE  = 2'd0,
      CFG_DRAIN = 2'd1,
      CFG_APPLY = 2'd2
   } cfg_state_e;

   // prescale = ceil(48 MHz / (baud * 8)), index = baud code (element 0 is 9600 baud)
   localparam logic [7:0][15:0] BAUD_PRESCALE = {
      16'd7, 16'd14, 16'd27, 16'd53, 16'd105, 16'd157, 16'd313, 16'd625
   };

   function automatic logic [15:0] baud_prescale(input logic [2:0] code);
      return BAUD_PRESCALE[code];
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock byte FIFO with valid/ready on both sides and fill count
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic [DATA_W-1:0]        in_data_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   output logic [DATA_W-1:0]        out_data_o,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [AW:0]       count_q;
   logic              up_q;
   logic              push;
   logic              pop;

   // up_q keeps the input side closed during the reset cycle itself
   assign in_ready_o  = up_q && (count_q != FULL_CNT);
   assign out_valid_o = (count_q != '0);
   assign out_data_o  = mem_q[rd_ptr_q];
   assign count_o     = count_q;
   assign push        = in_valid_i && in_ready_o;
   assign pop         = out_valid_o && out_ready_i;

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         up_q     <= 1'b0;
      end else begin
         up_q <= 1'b1;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= in_data_i;
   end

endmodule

// File: rtl/uart_bridge_sched.sv
// rtl/uart_bridge_sched.sv - USB CDC <-> UART flow scheduler: FIFOs, RX batching, safe baud changes
module uart_bridge_sched
   import uart_bridge_pkg::*;
#(
   parameter int          FIFO_DEPTH       = 16,
   parameter int          FLUSH_THRESH     = 8,
   parameter int          IDLE_TIMEOUT     = 4800,
   parameter logic [15:0] PRESCALE_DEFAULT = 16'h0035
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic [7:0]  usb_out_data_i,
   input  logic        usb_out_valid_i,
   output logic        usb_out_ready_o,
   output logic [7:0]  uart_tx_data_o,
   output logic        uart_tx_valid_o,
   input  logic        uart_tx_ready_i,
   input  logic        uart_tx_busy_i,
   input  logic [7:0]  uart_rx_data_i,
   input  logic        uart_rx_valid_i,
   output logic        uart_rx_ready_o,
   output logic [7:0]  usb_in_data_o,
   output logic        usb_in_valid_o,
   input  logic        usb_in_ready_i,
   input  logic [2:0]  baud_sel_i,
   input  logic        baud_load_i,
   output logic [15:0] prescale_o,
   output logic        cfg_busy_o
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int IW = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [CW-1:0] THRESH_CNT = CW'(FLUSH_THRESH);
   localparam logic [CW-1:0] ONE_CNT    = CW'(1);
   localparam logic [IW-1:0] IDLE_LAST  = IW'(IDLE_TIMEOUT - 1);

   rx_state_e   rx_state_q;
   cfg_state_e  cfg_state_q;
   logic [IW-1:0] idle_q;
   logic [2:0]  pend_q;
   logic        tx_hold_q;
   logic        cfg_busy_q;
   logic [15:0] prescale_q;

   logic          tx_fifo_valid;
   logic [CW-1:0] tx_count_unused;
   logic          rx_fifo_valid;
   logic [CW-1:0] rx_count;
   logic          rx_release;
   logic          rx_push;
   logic          rx_pop;

   assign rx_release      = (rx_state_q == RX_RELEASE);
   assign uart_tx_valid_o = tx_fifo_valid && !tx_hold_q;
   assign usb_in_valid_o  = rx_fifo_valid && rx_release;
   assign rx_push         = uart_rx_valid_i && uart_rx_ready_o;
   assign rx_pop          = usb_in_valid_o && usb_in_ready_i;
   assign prescale_o      = prescale_q;
   assign cfg_busy_o      = cfg_busy_q;

   sync_fifo #(.DATA_W(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .in_data_i   (usb_out_data_i),
      .in_valid_i  (usb_out_valid_i),
      .in_ready_o  (usb_out_ready_o),
      .out_data_o  (uart_tx_data_o),
      .out_valid_o (tx_fifo_valid),
      .out_ready_i (uart_tx_ready_i && !tx_hold_q),
      .count_o     (tx_count_unused)
   );

   sync_fifo #(.DATA_W(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .in_data_i   (uart_rx_data_i),
      .in_valid_i  (uart_rx_valid_i),
      .in_ready_o  (uart_rx_ready_o),
      .out_data_o  (usb_in_data_o),
      .out_valid_o (rx_fifo_valid),
      .out_ready_i (usb_in_ready_i && rx_release),
      .count_o     (rx_count)
   );

   // RX batching: hold bytes until a full batch or the line has gone quiet
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         rx_state_q <= RX_HOLD;
         idle_q     <= '0;
      end else begin
         if (rx_push || rx_count == '0)
            idle_q <= '0;
         else if (idle_q != IDLE_LAST)
            idle_q <= idle_q + 1'b1;

         case (rx_state_q)
            RX_HOLD:
               if (rx_count >= THRESH_CNT || (rx_count != '0 && idle_q == IDLE_LAST))
                  rx_state_q <= RX_RELEASE;
            RX_RELEASE:
               if (rx_pop && !rx_push && rx_count == ONE_CNT)
                  rx_state_q <= RX_HOLD;
            default: rx_state_q <= RX_HOLD;
         endcase
      end
   end

   // Baud change: stop feeding the UART without withdrawing a pending byte, wait for the frame to end
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         cfg_state_q <= CFG_IDLE;
         pend_q      <= '0;
         tx_hold_q   <= 1'b0;
         cfg_busy_q  <= 1'b0;
         prescale_q  <= PRESCALE_DEFAULT;
      end else begin
         case (cfg_state_q)
            CFG_IDLE: begin
               if (baud_load_i) begin
                  pend_q      <= baud_sel_i;
                  cfg_busy_q  <= 1'b1;
                  cfg_state_q <= CFG_DRAIN;
               end
            end
            CFG_DRAIN: begin
               if (baud_load_i) pend_q <= baud_sel_i;
               if (!uart_tx_valid_o || uart_tx_ready_i) tx_hold_q <= 1'b1;
               if (tx_hold_q && !uart_tx_busy_i && !uart_tx_valid_o)
                  cfg_state_q <= CFG_APPLY;
            end
            CFG_APPLY: begin
               prescale_q  <= baud_prescale(pend_q);
               tx_hold_q   <= 1'b0;
               cfg_busy_q  <= 1'b0;
               cfg_state_q <= CFG_IDLE;
            end
            default: cfg_state_q <= CFG_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_bridge_sched.sv
// tb/tb_uart_bridge_sched.sv - scoreboard bench for uart_bridge_sched
module tb_uart_bridge_sched;

   localparam int IDLE_TIMEOUT = 4800;

   logic        clk = 1'b0;
   logic        rstn;
   logic [7:0]  usb_out_data;
   logic        usb_out_valid;
   logic        usb_out_ready;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_valid;
   logic        uart_tx_ready;
   logic        uart_tx_busy;
   logic [7:0]  uart_rx_data;
   logic        uart_rx_valid;
   logic        uart_rx_ready;
   logic [7:0]  usb_in_data;
   logic        usb_in_valid;
   logic        usb_in_ready;
   logic [2:0]  baud_sel;
   logic        baud_load;
   logic [15:0] prescale;
   logic        cfg_busy;

   int pass_cnt  = 0;
   int total_cnt = 0;
   logic [7:0] tx_q[$];
   logic [7:0] rx_q[$];

   always #5 clk = ~clk;

   uart_bridge_sched dut (
      .clk_i           (clk),
      .rstn_i          (rstn),
      .usb_out_data_i  (usb_out_data),
      .usb_out_valid_i (usb_out_valid),
      .usb_out_ready_o (usb_out_ready),
      .uart_tx_data_o  (uart_tx_data),
      .uart_tx_valid_o (uart_tx_valid),
      .uart_tx_ready_i (uart_tx_ready),
      .uart_tx_busy_i  (uart_tx_busy),
      .uart_rx_data_i  (uart_rx_data),
      .uart_rx_valid_i (uart_rx_valid),
      .uart_rx_ready_o (uart_rx_ready),
      .usb_in_data_o   (usb_in_data),
      .usb_in_valid_o  (usb_in_valid),
      .usb_in_ready_i  (usb_in_ready),
      .baud_sel_i      (baud_sel),
      .baud_load_i     (baud_load),
      .prescale_o      (prescale),
      .cfg_busy_o      (cfg_busy)
   );

   task automatic test_reset();
      rstn = 1'b0; usb_out_data = '0; usb_out_valid = 1'b0; uart_tx_ready = 1'b0;
      uart_tx_busy = 1'b0; uart_rx_data = '0; uart_rx_valid = 1'b0; usb_in_ready = 1'b0;
      baud_sel = '0; baud_load = 1'b0;
      repeat (2) @(negedge clk);
      total_cnt++; if (prescale !== 16'h0035) $display("FAIL reset_prescale got %h want 0035", prescale); else pass_cnt++;
      total_cnt++; if (uart_tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %b want 0", uart_tx_valid); else pass_cnt++;
      total_cnt++; if (usb_in_valid !== 1'b0) $display("FAIL reset_in_valid got %b want 0", usb_in_valid); else pass_cnt++;
      total_cnt++; if (usb_out_ready !== 1'b0) $display("FAIL reset_out_ready got %b want 0", usb_out_ready); else pass_cnt++;
      total_cnt++; if (uart_rx_ready !== 1'b0) $display("FAIL reset_rx_ready got %b want 0", uart_rx_ready); else pass_cnt++;
      total_cnt++; if (cfg_busy !== 1'b0) $display("FAIL reset_cfg_busy got %b want 0", cfg_busy); else pass_cnt++;
      rstn = 1'b1;
      @(negedge clk);
      total_cnt++; if (usb_out_ready !== 1'b1) $display("FAIL post_reset_out_ready got %b want 1", usb_out_ready); else pass_cnt++;
      total_cnt++; if (uart_rx_ready !== 1'b1) $display("FAIL post_reset_rx_ready got %b want 1", uart_rx_ready); else pass_cnt++;
   endtask

   task automatic test_tx_stream();
      logic [7:0] exp_b;
      uart_tx_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         exp_b = 8'h41 + 8'(i);
         usb_out_data = exp_b; usb_out_valid = 1'b1;
         tx_q.push_back(exp_b);
         @(negedge clk);
      end
      usb_out_valid = 1'b0;
      total_cnt++; if (usb_out_ready !== 1'b0) $display("FAIL tx_full_ready got %b want 0", usb_out_ready); else pass_cnt++;
      total_cnt++; if (uart_tx_valid !== 1'b1) $display("FAIL tx_full_valid got %b want 1", uart_tx_valid); else pass_cnt++;
      uart_tx_ready = 1'b1;
      for (int c = 0; c < 40 && tx_q.size() > 0; c++) begin
         if (uart_tx_valid) begin
            exp_b = tx_q.pop_front();
            total_cnt++; if (uart_tx_data !== exp_b) $display("FAIL tx_data got %h want %h", uart_tx_data, exp_b); else pass_cnt++;
         end
         @(negedge clk);
      end
      uart_tx_ready = 1'b0;
      total_cnt++; if (tx_q.size() != 0) $display("FAIL tx_drain_left got %0d want 0", tx_q.size()); else pass_cnt++;
      total_cnt++; if (uart_tx_valid !== 1'b0) $display("FAIL tx_empty_valid got %b want 0", uart_tx_valid); else pass_cnt++;
   endtask

   task automatic test_rx_threshold();
      logic [7:0] exp_b, prev_data;
      logic       prev_valid, prev_hs;
      usb_in_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp_b = 8'hA0 + 8'(i);
         uart_rx_data = exp_b; uart_rx_valid = 1'b1;
         rx_q.push_back(exp_b);
         @(negedge clk);
      end
      uart_rx_valid = 1'b0;
      total_cnt++; if (usb_in_valid !== 1'b0) $display("FAIL rx_thresh_early got %b want 0", usb_in_valid); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (usb_in_valid !== 1'b1) $display("FAIL rx_thresh_rise got %b want 1", usb_in_valid); else pass_cnt++;
      prev_valid = 1'b0; prev_hs = 1'b0; prev_data = '0;
      for (int c = 0; c < 80 && rx_q.size() > 0; c++) begin
         if (prev_valid && !prev_hs) begin
            total_cnt++;
            if (usb_in_valid !== 1'b1 || usb_in_data !== prev_data)
               $display("FAIL rx_valid_stable got %b/%h want 1/%h", usb_in_valid, usb_in_data, prev_data);
            else pass_cnt++;
         end
         usb_in_ready = c[0];
         prev_valid = usb_in_valid; prev_data = usb_in_data;
         prev_hs = usb_in_valid && usb_in_ready;
         if (prev_hs) begin
            exp_b = rx_q.pop_front();
            total_cnt++; if (usb_in_data !== exp_b) $display("FAIL rx_thresh_data got %h want %h", usb_in_data, exp_b); else pass_cnt++;
         end
         @(negedge clk);
      end
      usb_in_ready = 1'b0;
      total_cnt++; if (rx_q.size() != 0) $display("FAIL rx_thresh_left got %0d want 0", rx_q.size()); else pass_cnt++;
      total_cnt++; if (usb_in_valid !== 1'b0) $display("FAIL rx_thresh_end_valid got %b want 0", usb_in_valid); else pass_cnt++;
   endtask

   task automatic test_rx_timeout();
      logic [7:0] exp_b;
      int k;
      usb_in_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         exp_b = 8'hC0 + 8'(i);
         uart_rx_data = exp_b; uart_rx_valid = 1'b1;
         rx_q.push_back(exp_b);
         @(negedge clk);
      end
      uart_rx_valid = 1'b0;
      k = 0;
      while (usb_in_valid !== 1'b1 && k < IDLE_TIMEOUT + 20) begin
         @(negedge clk);
         k++;
      end
      total_cnt++; if (k != IDLE_TIMEOUT) $display("FAIL rx_timeout_latency got %0d want %0d", k, IDLE_TIMEOUT); else pass_cnt++;
      usb_in_ready = 1'b1;
      for (int c = 0; c < 10 && rx_q.size() > 0; c++) begin
         if (usb_in_valid) begin
            exp_b = rx_q.pop_front();
            total_cnt++; if (usb_in_data !== exp_b) $display("FAIL rx_timeout_data got %h want %h", usb_in_data, exp_b); else pass_cnt++;
         end
         @(negedge clk);
      end
      total_cnt++; if (usb_in_valid !== 1'b0) $display("FAIL rx_timeout_end_valid got %b want 0", usb_in_valid); else pass_cnt++;
      // one more byte must be held again, proving the FSM went back to HOLD
      uart_rx_data = 8'hCF; uart_rx_valid = 1'b1; rx_q.push_back(8'hCF);
      @(negedge clk);
      uart_rx_valid = 1'b0;
      total_cnt++; if (usb_in_valid !== 1'b0) $display("FAIL rx_back_to_hold got %b want 0", usb_in_valid); else pass_cnt++;
      for (int c = 0; c < IDLE_TIMEOUT + 20 && rx_q.size() > 0; c++) begin
         if (usb_in_valid) begin
            exp_b = rx_q.pop_front();
            total_cnt++; if (usb_in_data !== exp_b) $display("FAIL rx_timeout2_data got %h want %h", usb_in_data, exp_b); else pass_cnt++;
         end
         @(negedge clk);
      end
      usb_in_ready = 1'b0;
      total_cnt++; if (rx_q.size() != 0) $display("FAIL rx_timeout_left got %0d want 0", rx_q.size()); else pass_cnt++;
   endtask

   task automatic test_baud_change();
      logic [7:0] exp_b;
      int k;
      uart_tx_busy = 1'b1; uart_tx_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         exp_b = 8'h61 + 8'(i);
         usb_out_data = exp_b; usb_out_valid = 1'b1; tx_q.push_back(exp_b);
         @(negedge clk);
      end
      usb_out_valid = 1'b0;
      total_cnt++; if (uart_tx_valid !== 1'b1) $display("FAIL baud_pre_valid got %b want 1", uart_tx_valid); else pass_cnt++;
      baud_sel = 3'd7; baud_load = 1'b1;
      @(negedge clk);
      baud_load = 1'b0;
      total_cnt++; if (cfg_busy !== 1'b1) $display("FAIL baud_cfg_busy got %b want 1", cfg_busy); else pass_cnt++;
      total_cnt++; if (uart_tx_valid !== 1'b1) $display("FAIL baud_valid_held got %b want 1", uart_tx_valid); else pass_cnt++;
      uart_tx_ready = 1'b1;
      exp_b = tx_q.pop_front();
      total_cnt++; if (uart_tx_data !== exp_b) $display("FAIL baud_pending_data got %h want %h", uart_tx_data, exp_b); else pass_cnt++;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total_cnt++; if (uart_tx_valid !== 1'b0) $display("FAIL baud_tx_blocked got %b want 0", uart_tx_valid); else pass_cnt++;
      end
      total_cnt++; if (prescale !== 16'h0035) $display("FAIL baud_early_prescale got %h want 0035", prescale); else pass_cnt++;
      uart_tx_busy = 1'b0;
      k = 0;
      while (prescale !== 16'd7 && k < 6) begin
         @(negedge clk);
         k++;
      end
      total_cnt++; if (prescale !== 16'd7) $display("FAIL baud_prescale got %0d want 7", prescale); else pass_cnt++;
      total_cnt++; if (k != 2) $display("FAIL baud_apply_latency got %0d want 2", k); else pass_cnt++;
      total_cnt++; if (cfg_busy !== 1'b0) $display("FAIL baud_cfg_done got %b want 0", cfg_busy); else pass_cnt++;
      for (int c = 0; c < 6 && tx_q.size() > 0; c++) begin
         if (uart_tx_valid) begin
            exp_b = tx_q.pop_front();
            total_cnt++; if (uart_tx_data !== exp_b) $display("FAIL baud_resume_data got %h want %h", uart_tx_data, exp_b); else pass_cnt++;
         end
         @(negedge clk);
      end
      uart_tx_ready = 1'b0;
      total_cnt++; if (tx_q.size() != 0) $display("FAIL baud_resume_left got %0d want 0", tx_q.size()); else pass_cnt++;
   endtask

   task automatic test_double_load();
      logic [7:0] exp_b;
      int k;
      uart_tx_busy = 1'b1; uart_tx_ready = 1'b0;
      baud_sel = 3'd2; baud_load = 1'b1;
      @(negedge clk);
      baud_sel = 3'd5;
      @(negedge clk);
      baud_load = 1'b0;
      usb_out_data = 8'h77; usb_out_valid = 1'b1; tx_q.push_back(8'h77);
      @(negedge clk);
      usb_out_valid = 1'b0;
      total_cnt++; if (uart_tx_valid !== 1'b0) $display("FAIL dl_tx_blocked got %b want 0", uart_tx_valid); else pass_cnt++;
      total_cnt++; if (prescale !== 16'd7) $display("FAIL dl_prescale_hold got %0d want 7", prescale); else pass_cnt++;
      // RX keeps flowing during the baud change, with push and pop in the same cycles
      usb_in_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp_b = 8'hD0 + 8'(i);
         uart_rx_data = exp_b; uart_rx_valid = 1'b1; rx_q.push_back(exp_b);
         @(negedge clk);
      end
      uart_rx_valid = 1'b0;
      @(negedge clk);
      usb_in_ready = 1'b1;
      for (int c = 0; c < 40 && rx_q.size() > 0; c++) begin
         if (usb_in_valid) begin
            exp_b = rx_q.pop_front();
            total_cnt++; if (usb_in_data !== exp_b) $display("FAIL dl_rx_data got %h want %h", usb_in_data, exp_b); else pass_cnt++;
         end
         if (c < 4) begin
            exp_b = 8'hD8 + 8'(c);
            uart_rx_data = exp_b; uart_rx_valid = 1'b1; rx_q.push_back(exp_b);
         end else begin
            uart_rx_valid = 1'b0;
         end
         @(negedge clk);
      end
      uart_rx_valid = 1'b0; usb_in_ready = 1'b0;
      total_cnt++; if (rx_q.size() != 0) $display("FAIL dl_rx_left got %0d want 0", rx_q.size()); else pass_cnt++;
      total_cnt++; if (usb_in_valid !== 1'b0) $display("FAIL dl_rx_end_valid got %b want 0", usb_in_valid); else pass_cnt++;
      total_cnt++; if (cfg_busy !== 1'b1) $display("FAIL dl_still_busy got %b want 1", cfg_busy); else pass_cnt++;
      uart_tx_busy = 1'b0;
      k = 0;
      while (cfg_busy !== 1'b0 && k < 6) begin
         @(negedge clk);
         k++;
      end
      total_cnt++; if (prescale !== 16'd27) $display("FAIL dl_prescale got %0d want 27", prescale); else pass_cnt++;
      uart_tx_ready = 1'b1;
      for (int c = 0; c < 6 && tx_q.size() > 0; c++) begin
         if (uart_tx_valid) begin
            exp_b = tx_q.pop_front();
            total_cnt++; if (uart_tx_data !== exp_b) $display("FAIL dl_tx_data got %h want %h", uart_tx_data, exp_b); else pass_cnt++;
         end
         @(negedge clk);
      end
      uart_tx_ready = 1'b0;
      total_cnt++; if (tx_q.size() != 0) $display("FAIL dl_tx_left got %0d want 0", tx_q.size()); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_tx_stream();
      test_rx_threshold();
      test_rx_timeout();
      test_baud_change();
      test_double_load();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
